// File: rtl/gauss_window_fetch_if.sv
// Signal bundle shared by the Gaussian window fetcher, its SRAM read port
// and the downstream 5x5 filter stage.
interface gauss_window_fetch_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64
);
  logic                startEn;
  logic [ADDR_W-1:0]   read_addr;
  logic [DATA_W-1:0]   q;
  logic [5*DATA_W-1:0] col_data;
  logic                col_valid;
  logic                getNext;
  logic                busy;
  logic                done;

  modport master (
    input  startEn, q, getNext,
    output read_addr, col_data, col_valid, busy, done
  );

  modport slave (
    output startEn, q, getNext,
    input  read_addr, col_data, col_valid, busy, done
  );
endinterface

// File: rtl/gauss_window_fetch.sv
// Read sequencer for the 5x5 Gaussian filter: for every column it reads five
// vertically stacked SRAM words (base, base-1 row, ... base-4 rows), packs
// them into one 5-word column and offers it on a valid/getNext handshake.
// One finished column can wait in the assembly buffer while the previous one
// is still unconsumed; beyond that, new column fetches stall.
module gauss_window_fetch #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 64,
  parameter int ROW_STRIDE = 256,
  parameter int START_ADDR = 1024,
  parameter int NUM_COLS   = 48976
) (
  input  logic                 clk,
  input  logic                 reset,
  gauss_window_fetch_if.master bus
);

  localparam int                CNT_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [CNT_W-1:0]  LAST_COL = CNT_W'(NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_STALL, ST_FLUSH} state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_readAddr;
  logic [ADDR_W-1:0]   w_offset;
  logic [2:0]          r_k;
  logic [2:0]          r_kd;
  logic                r_qValid;
  logic [CNT_W-1:0]    r_colCnt;
  logic [DATA_W-1:0]   r_asm [0:4];
  logic                r_asmFull;
  logic [5*DATA_W-1:0] r_colData;
  logic [5*DATA_W-1:0] w_capCol;
  logic [5*DATA_W-1:0] w_asmCol;
  logic                r_colValid;
  logic                r_busy;
  logic                r_done;
  logic                w_accept;
  logic                w_capLast;
  logic                w_park;
  logic                w_start;
  logic                w_issue;
  logic                w_newCol;
  logic                w_finish;

  // A transfer happens only when a column is actually on offer.
  assign w_accept  = r_colValid & bus.getNext;
  // Word 4 arriving completes the column under assembly.
  assign w_capLast = r_qValid & (r_kd == 3'd4);
  // The completed column has nowhere to go and must wait in the buffer.
  assign w_park    = w_capLast & r_colValid & ~bus.getNext;
  // Row offset of the next word above the current one (wraps modulo 2^ADDR_W).
  assign w_offset  = ADDR_W'((32'(r_k) + 32'd1) * 32'(ROW_STRIDE));
  assign w_capCol  = {bus.q, r_asm[3], r_asm[2], r_asm[1], r_asm[0]};
  assign w_asmCol  = {r_asm[4], r_asm[3], r_asm[2], r_asm[1], r_asm[0]};

  assign bus.read_addr = r_readAddr;
  assign bus.col_data  = r_colData;
  assign bus.col_valid = r_colValid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic plus the per-edge control strobes for the datapath.
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    w_newCol    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.startEn) begin
          w_stateNext = ST_ISSUE;
          w_start     = 1'b1;
        end
      end
      ST_ISSUE: begin
        if ((r_k == 3'd0) && w_park) begin
          w_stateNext = ST_STALL;
        end else begin
          w_issue = 1'b1;
          if (r_k == 3'd4) begin
            if (r_colCnt == LAST_COL) begin
              w_stateNext = ST_FLUSH;
            end else begin
              w_newCol = 1'b1;
            end
          end
        end
      end
      ST_STALL: begin
        if (w_accept) begin
          w_stateNext = ST_ISSUE;
        end
      end
      ST_FLUSH: begin
        if (w_accept && !r_asmFull && !r_qValid) begin
          w_stateNext = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Address sequencing, word capture and column hand-off to the filter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base     <= START;
      r_readAddr <= START;
      r_k        <= '0;
      r_kd       <= '0;
      r_qValid   <= 1'b0;
      r_colCnt   <= '0;
      for (int i = 0; i < 5; i++) begin
        r_asm[i] <= '0;
      end
      r_asmFull  <= 1'b0;
      r_colData  <= '0;
      r_colValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_qValid <= w_issue;
      r_kd     <= r_k;

      if (w_start) begin
        r_base     <= START;
        r_readAddr <= START;
        r_k        <= '0;
        r_colCnt   <= '0;
        r_busy     <= 1'b1;
      end

      if (w_issue) begin
        if (r_k == 3'd4) begin
          if (w_newCol) begin
            r_base     <= r_base + 1'b1;
            r_readAddr <= r_base + 1'b1;
            r_k        <= '0;
            r_colCnt   <= r_colCnt + 1'b1;
          end
        end else begin
          r_readAddr <= r_base - w_offset;
          r_k        <= r_k + 3'd1;
        end
      end

      if (r_qValid) begin
        r_asm[r_kd] <= bus.q;
      end

      if (w_capLast) begin
        if (!r_colValid || w_accept) begin
          r_colData  <= w_capCol;
          r_colValid <= 1'b1;
        end else begin
          r_asmFull <= 1'b1;
        end
      end else if (w_accept) begin
        if (r_asmFull) begin
          r_colData <= w_asmCol;
          r_asmFull <= 1'b0;
        end else begin
          r_colValid <= 1'b0;
        end
      end

      if (w_finish) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_base <= START;
      end
    end
  end

endmodule

// File: tb/tb_gauss_window_fetch.sv
// Directed bench for gauss_window_fetch: a four-column instance with a column
// scoreboard, and a one-column instance for the single-column and wrap cases.
module tb_gauss_window_fetch;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 64;
  localparam int COL_W  = 5 * DATA_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int nChecks   = 0;
  int nErrors   = 0;
  int acceptCnt = 0;

  logic [COL_W-1:0] sb [$];

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  gauss_window_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
  gauss_window_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  gauss_window_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_STRIDE(256), .START_ADDR(1024), .NUM_COLS(4)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  gauss_window_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_STRIDE(256), .START_ADDR(1024), .NUM_COLS(1)
  ) u_dut1 (
    .clk(clk),
    .reset(reset),
    .bus(bus1.master)
  );

  // SRAM models: registered read, the word at address a holds the value a.
  always @(posedge clk) begin
    bus.q  <= DATA_W'(bus.read_addr);
    bus1.q <= DATA_W'(bus1.read_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [COL_W-1:0] obs,
                             input logic [COL_W-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkScalar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Column c of a run starting at 1024: word k comes from (1024+c) - 256*k.
  function automatic logic [COL_W-1:0] expCol(input int c);
    logic [COL_W-1:0]  v;
    logic [ADDR_W-1:0] a;
    v = '0;
    for (int k = 0; k < 5; k++) begin
      a = ADDR_W'(1024 + c - 256 * k);
      v[64*k +: 64] = 64'(a);
    end
    return v;
  endfunction

  // Queue the expected columns of a run, then pulse startEn for one cycle.
  task automatic applyStimulus(input int nCols);
    for (int c = 0; c < nCols; c++) begin
      sb.push_back(expCol(c));
    end
    bus.startEn = 1'b1;
    tick();
    bus.startEn = 1'b0;
  endtask

  // Scoreboard monitor: accepted columns are popped in order, held ones must not change.
  always @(negedge clk) begin
    if (reset && bus.col_valid) begin
      if (sb.size() == 0) begin
        checkScalar("unexpected_col", 32'(bus.col_valid), 0);
      end else if (bus.getNext) begin
        checkOutput("col_data", bus.col_data, sb.pop_front());
        acceptCnt++;
      end else begin
        checkOutput("col_hold", bus.col_data, sb[0]);
      end
    end
  end

  initial begin
    int   vCnt;
    int   lastV;
    int   doneAt;
    logic doneSeen;

    bus.startEn  = 1'b0;
    bus.getNext  = 1'b0;
    bus1.startEn = 1'b0;
    bus1.getNext = 1'b0;
    reset        = 1'b0;
    repeat (3) tick();

    // Reset values on both instances.
    checkScalar("rst_addr", 32'(bus.read_addr), 1024);
    checkScalar("rst_valid", 32'(bus.col_valid), 0);
    checkScalar("rst_busy", 32'(bus.busy), 0);
    checkScalar("rst_done", 32'(bus.done), 0);
    checkOutput("rst_data", bus.col_data, '0);
    checkScalar("rst1_addr", 32'(bus1.read_addr), 1024);
    reset = 1'b1;
    tick();

    // Single column, with the word-4 wrap down to address 0.
    bus1.getNext = 1'b1;
    bus1.startEn = 1'b1;
    tick();
    bus1.startEn = 1'b0;
    checkScalar("s_busy", 32'(bus1.busy), 1);
    for (int k = 0; k < 5; k++) begin
      checkScalar("s_addr", 32'(bus1.read_addr), 32'(1024 - 256 * k));
      if (k < 4) tick();
    end
    tick();
    checkScalar("s_valid_e5", 32'(bus1.col_valid), 0);
    checkScalar("s_addr_hold", 32'(bus1.read_addr), 0);
    tick();
    checkScalar("s_valid_e6", 32'(bus1.col_valid), 1);
    checkOutput("s_col", bus1.col_data, expCol(0));
    checkOutput("s_wrap_w4", COL_W'(bus1.col_data[COL_W-1 -: DATA_W]), '0);
    tick();
    checkScalar("s_done", 32'(bus1.done), 1);
    checkScalar("s_busy_end", 32'(bus1.busy), 0);
    checkScalar("s_valid_end", 32'(bus1.col_valid), 0);
    tick();
    checkScalar("s_done_pulse", 32'(bus1.done), 0);
    bus1.getNext = 1'b0;

    // Streaming with getNext held high: one column every five cycles.
    bus.getNext = 1'b1;
    acceptCnt   = 0;
    applyStimulus(4);
    vCnt   = 0;
    lastV  = 0;
    doneAt = -1;
    for (int t = 1; t <= 40 && doneAt < 0; t++) begin
      tick();
      if (bus.col_valid) begin
        if (vCnt == 0) checkScalar("st_first", t, 6);
        else           checkScalar("st_gap", t - lastV, 5);
        lastV = t;
        vCnt++;
      end
      if (bus.done) doneAt = t;
    end
    checkScalar("st_cols", vCnt, 4);
    checkScalar("st_done_at", doneAt, lastV + 1);
    checkScalar("st_accepts", acceptCnt, 4);
    checkScalar("st_sb_empty", sb.size(), 0);
    checkScalar("st_busy", 32'(bus.busy), 0);

    // Backpressure: consumer stalls for 30 cycles after start.
    bus.getNext = 1'b0;
    acceptCnt   = 0;
    applyStimulus(4);
    repeat (15) tick();
    checkScalar("bp_addr15", 32'(bus.read_addr), 1026);
    repeat (15) tick();
    checkScalar("bp_addr30", 32'(bus.read_addr), 1026);
    checkScalar("bp_valid", 32'(bus.col_valid), 1);
    checkOutput("bp_col0", bus.col_data, expCol(0));
    checkScalar("bp_pending", sb.size(), 4);
    checkScalar("bp_busy", 32'(bus.busy), 1);
    bus.getNext = 1'b1;
    doneSeen = 1'b0;
    for (int t = 1; t <= 60 && !doneSeen; t++) begin
      tick();
      if (bus.done) doneSeen = 1'b1;
    end
    checkScalar("bp_done", 32'(doneSeen), 1);
    checkScalar("bp_accepts", acceptCnt, 4);
    checkScalar("bp_sb_empty", sb.size(), 0);

    // Reset asserted at cycle 8 of a run aborts it immediately.
    acceptCnt = 0;
    applyStimulus(4);
    repeat (8) tick();
    checkScalar("rm_busy_before", 32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    checkScalar("rm_addr", 32'(bus.read_addr), 1024);
    checkScalar("rm_valid", 32'(bus.col_valid), 0);
    checkScalar("rm_busy", 32'(bus.busy), 0);
    checkScalar("rm_done", 32'(bus.done), 0);
    checkOutput("rm_data", bus.col_data, '0);
    sb.delete();
    tick();
    reset = 1'b1;
    tick();
    checkScalar("rm_idle", 32'(bus.busy), 0);

    // Restart from 1024, with extra start pulses at cycles 3 and 12 that must be ignored.
    acceptCnt = 0;
    applyStimulus(4);
    checkScalar("rs_addr0", 32'(bus.read_addr), 1024);
    vCnt   = 0;
    doneAt = -1;
    for (int t = 1; t <= 40 && doneAt < 0; t++) begin
      bus.startEn = (t == 3) || (t == 12);
      tick();
      bus.startEn = 1'b0;
      if (t <= 5) checkScalar("rs_addr", 32'(bus.read_addr), (t < 5) ? 32'(1024 - 256 * t) : 32'd1025);
      if (bus.col_valid) vCnt++;
      if (bus.done) doneAt = t;
    end
    checkScalar("rs_cols", vCnt, 4);
    checkScalar("rs_done_at", doneAt, 22);
    checkScalar("rs_accepts", acceptCnt, 4);
    checkScalar("rs_sb_empty", sb.size(), 0);
    repeat (5) tick();
    checkScalar("rs_stay_idle", 32'(bus.busy), 0);
    checkScalar("rs_addr_held", 32'(bus.read_addr), 3);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
